tft_window_scanner: RTL
=======================

// Module: tft_window_scanner
// PURPOSE
//  Walks a rectangular pixel window of the TFT framebuffer and streams one (x, y, addr) beat per pixel.
//  Pixels come out over a valid/ready handshake and addresses are generated incrementally.
//  It sits between the draw/fill engines and the framebuffer RAM port, and replaces per-pixel address math.
//  Scan order is selectable per job: column-major (addr = x*V_PIXELS + y) or row-major (addr = y*H_PIXELS + x).
// PARAMETERS
//  H_PIXELS  480  display width in pixels
//  V_PIXELS  272  display height in pixels
//  X_W       9    coordinate width for x, >= clog2(H_PIXELS)
//  Y_W       9    coordinate width for y, >= clog2(V_PIXELS)
//  ADDR_W    17   address width, >= clog2(H_PIXELS*V_PIXELS)
// PORTS
//  clk        in   1       system clock, all logic on the rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       launch a job; sampled only in IDLE
//  abort      in   1       cancel the current job; synchronous
//  col_major  in   1       1 = column-major, 0 = row-major; latched at start
//  win_x0     in   X_W     window left edge, inclusive
//  win_y0     in   Y_W     window top edge, inclusive
//  win_x1     in   X_W     window right edge, inclusive
//  win_y1     in   Y_W     window bottom edge, inclusive
//  out_valid  out  1       beat valid
//  out_ready  in   1       downstream accepts the beat
//  out_x      out  X_W     pixel x of the current beat
//  out_y      out  Y_W     pixel y of the current beat
//  out_addr   out  ADDR_W  framebuffer address of the current beat
//  out_last   out  1       final beat of the window; qualified by out_valid
//  busy       out  1       high whenever the FSM is not in IDLE
//  done       out  1       one-cycle pulse when a job completes normally
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0; all internal registers are 0.
//  FSM states: IDLE, SETUP, RUN, DONE.
//   IDLE -> SETUP on start. In the same edge, latch the window coordinates and col_major.
//   SETUP (one cycle): clamp coordinates, then compute the base address.
//    x > H_PIXELS-1 becomes H_PIXELS-1; y > V_PIXELS-1 becomes V_PIXELS-1.
//    If x1 < x0 after clamping, x1 := x0. Same rule for y.
//    Base address = address of (x0, y0). SETUP -> RUN.
//   RUN: out_valid=1. A beat transfers on out_valid & out_ready.
//    While not transferred, out_x, out_y, out_addr and out_last hold stable.
//   RUN -> DONE when the last beat transfers.
//   DONE: done=1 for exactly one cycle, out_valid=0, then -> IDLE.
//  Latency: start sampled at edge N gives first out_valid after edge N+2. No bubbles while out_ready=1.
//  Column-major stepping: inner loop on y, outer loop on x.
//   If y < y1: y+1, addr+1.
//   Else: y := y0, x+1, addr += V_PIXELS - (y1-y0).
//  Row-major stepping: the same pattern with the x and y roles swapped, using H_PIXELS.
//  out_last = (x==x1) & (y==y1). A 1x1 window gives a single beat with out_last=1.
//  All address arithmetic is ADDR_W bits, unsigned. No multiply outside SETUP.
//  abort has priority over every other event, including a beat transferring in the same cycle.
//   Effect: -> IDLE next edge, out_valid=0, done stays 0.
//   A beat transferring in the abort cycle still counts as accepted downstream.
//  start while busy is ignored. start and abort together in IDLE: abort wins, no job starts.
//  rst_n low mid-job: immediate return to reset values. No done pulse.
//  busy is 1 in SETUP, RUN and DONE.
// STRUCTURE
//  Shared header tft_defs.vh:
//   - default H_PIXELS/V_PIXELS
//   - FSM state encodings (2-bit)
//   - scan-mode encodings
//  Sub-module tft_addr_calc: combinational (x, y, col_major) -> base address.
//   Parametrised by H_PIXELS, V_PIXELS and ADDR_W; used only in SETUP.
//  Top level: FSM, x/y/addr counters, clamp logic, output register stage.
// TESTING
//  1 Full screen, col_major=1, window (0,0)-(479,271), out_ready=1:
//    130560 beats at 1 beat/clk; addr 0..130559 in order; out_last only on addr 130559.
//    done pulses one cycle later.
//  2 Window (10,5)-(11,6), col_major=1:
//    addrs 2725, 2726, 2997, 2998; (x,y) = (10,5), (10,6), (11,5), (11,6).
//  3 Same window, col_major=0:
//    addrs 2410, 2411, 2890, 2891; out_last on 2891.
//  4 Clamp: window (500,300)-(600,400):
//    exactly one beat, x=479, y=271, addr 130559, out_last=1.
//  5 Backpressure: window (0,0)-(0,3); hold out_ready=0 for 3 cycles at beat 2.
//    Beat 2 (addr 2) stays stable; all 4 addrs delivered once each; none duplicated or skipped.
//  6 Abort and reset: abort at beat 5 of a full-screen job -> IDLE next cycle, no done.
//    Then rst_n pulse mid-job -> all outputs 0 immediately.
//    A fresh start afterwards replays test 2 correctly.

Source files
------------

// File: rtl/tft_window_scanner_pkg.sv
// tft_window_scanner_pkg: shared defaults, FSM state and scan-mode encodings for the window scanner.
package tft_window_scanner_pkg;
    localparam int H_PIXELS_DEF = 480;
    localparam int V_PIXELS_DEF = 272;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    typedef enum logic {
        SCAN_ROW = 1'b0,
        SCAN_COL = 1'b1
    } scan_t;
endpackage

// File: rtl/tft_window_scanner_addr_calc.sv
// tft_window_scanner_addr_calc: combinational framebuffer address of one pixel for either scan order.
module tft_window_scanner_addr_calc
    import tft_window_scanner_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_PIXELS = V_PIXELS_DEF,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int ADDR_W   = 17
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic              col_major,
    output logic [ADDR_W-1:0] addr
);
    always_comb
        addr = (scan_t'(col_major) == SCAN_COL) ? ADDR_W'(x) * ADDR_W'(V_PIXELS) + ADDR_W'(y)
                                                : ADDR_W'(y) * ADDR_W'(H_PIXELS) + ADDR_W'(x);
endmodule

// File: rtl/tft_window_scanner.sv
// tft_window_scanner: walks a clamped pixel window and streams (x, y, addr) beats over valid/ready.
module tft_window_scanner
    import tft_window_scanner_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_PIXELS = V_PIXELS_DEF,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              col_major,
    input  logic [X_W-1:0]    win_x0,
    input  logic [Y_W-1:0]    win_y0,
    input  logic [X_W-1:0]    win_x1,
    input  logic [Y_W-1:0]    win_y1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_PIXELS - 1);

    state_t              state_q, state_d;
    logic                col_q, col_d, more_q, more_d, ov_q, ov_d, ol_q, ol_d;
    logic [X_W-1:0]      x0_q, x0_d, x1_q, x1_d, cx_q, cx_d, ox_q, ox_d, xa, xb, xc1;
    logic [Y_W-1:0]      y0_q, y0_d, y1_q, y1_d, cy_q, cy_d, oy_q, oy_d, ya, yb, yc1;
    logic [ADDR_W-1:0]   ca_q, ca_d, oa_q, oa_d, base;
    logic                fire, load, gen_last, step_inner;

    // Clamping works on the raw corners latched at start; only meaningful during SETUP.
    assign xa  = x0_q > X_MAX ? X_MAX : x0_q;
    assign xb  = x1_q > X_MAX ? X_MAX : x1_q;
    assign xc1 = xb < xa ? xa : xb;
    assign ya  = y0_q > Y_MAX ? Y_MAX : y0_q;
    assign yb  = y1_q > Y_MAX ? Y_MAX : y1_q;
    assign yc1 = yb < ya ? ya : yb;

    tft_window_scanner_addr_calc #(
        .H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) u_addr_calc (
        .x(xa), .y(ya), .col_major(col_q), .addr(base)
    );

    // Counters hold the next beat to issue; the output stage refills whenever it empties or transfers.
    assign fire       = ov_q & out_ready;
    assign load       = (state_q == ST_RUN) & more_q & (~ov_q | fire);
    assign gen_last   = (cx_q == x1_q) & (cy_q == y1_q);
    assign step_inner = col_q ? (cy_q < y1_q) : (cx_q < x1_q);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;

    always_comb
        state_d = abort                                  ? ST_IDLE  :
                  (state_q == ST_IDLE && start)          ? ST_SETUP :
                  (state_q == ST_SETUP)                  ? ST_RUN   :
                  (state_q == ST_RUN && fire && ol_q)    ? ST_DONE  :
                  (state_q == ST_DONE)                   ? ST_IDLE  : state_q;

    always_comb begin
        col_d  = col_q;  x0_d = x0_q; x1_d = x1_q; y0_d = y0_q; y1_d = y1_q;
        cx_d   = cx_q;   cy_d = cy_q; ca_d = ca_q; more_d = more_q;
        ov_d   = ov_q;   ox_d = ox_q; oy_d = oy_q; oa_d = oa_q; ol_d = ol_q;
        if (state_q == ST_IDLE && start && !abort) begin
            col_d = col_major; x0_d = win_x0; y0_d = win_y0; x1_d = win_x1; y1_d = win_y1;
        end
        if (state_q == ST_SETUP) begin
            x0_d = xa; x1_d = xc1; y0_d = ya; y1_d = yc1;
            cx_d = xa; cy_d = ya; ca_d = base; more_d = 1'b1;
        end
        if (load) begin
            ox_d = cx_q; oy_d = cy_q; oa_d = ca_q; ol_d = gen_last; ov_d = 1'b1; more_d = ~gen_last;
            if (step_inner) begin
                cx_d = col_q ? cx_q : cx_q + X_W'(1);
                cy_d = col_q ? cy_q + Y_W'(1) : cy_q;
                ca_d = ca_q + ADDR_W'(1);
            end else if (col_q) begin
                cy_d = y0_q;
                cx_d = cx_q + X_W'(1);
                ca_d = ca_q + ADDR_W'(V_PIXELS) - ADDR_W'(y1_q - y0_q);
            end else begin
                cx_d = x0_q;
                cy_d = cy_q + Y_W'(1);
                ca_d = ca_q + ADDR_W'(H_PIXELS) - ADDR_W'(x1_q - x0_q);
            end
        end else if (fire) begin
            ov_d = 1'b0;
        end
        if (abort) begin
            ov_d   = 1'b0;
            more_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col_q <= 1'b0; x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
            cx_q  <= '0;   cy_q <= '0; ca_q <= '0; more_q <= 1'b0;
            ov_q  <= 1'b0; ox_q <= '0; oy_q <= '0; oa_q <= '0; ol_q <= 1'b0;
        end else begin
            col_q <= col_d; x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
            cx_q  <= cx_d;  cy_q <= cy_d; ca_q <= ca_d; more_q <= more_d;
            ov_q  <= ov_d;  ox_q <= ox_d; oy_q <= oy_d; oa_q <= oa_d; ol_q <= ol_d;
        end

    always_comb begin
        out_valid = ov_q;
        out_x     = ox_q;
        out_y     = oy_q;
        out_addr  = oa_q;
        out_last  = ol_q & ov_q;
        busy      = state_q != ST_IDLE;
        done      = state_q == ST_DONE;
    end
endmodule
